prog_loader: RTL and testbench

Boot-time program/data loader sitting upstream of the instruction and data BRAMs and the PC. It accepts a byte stream over a valid/ready handshake (e.g. from a UART receiver) and assembles little-endian 32-bit words. Each word is written into the instruction or data BRAM write port at consecutive 4-byte-aligned addresses. On a "go" command it releases the CPU by dropping the PC stall, replacing the manual BRAM-preload sequence used in simulation.

---
 rtl/prog_loader.sv | 165 ++++++++++++++++
 tb/tb_prog_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time loader: turns a byte stream into little-endian 32-bit BRAM writes
// for the instruction or data memory, then releases the CPU on a go command.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a command byte ('I', 'D', 'G')
// S_CNT_LO | waiting for the low byte of the segment word count
// S_CNT_HI | waiting for the high byte; zero count returns to idle
// S_DATA   | collecting data bytes, one BRAM write per 4 bytes
// S_DONE   | go received, CPU running; terminal until reset
// S_ERR    | protocol error, CPU held; terminal until reset
module prog_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  cpu_stall,
    output logic                  load_done,
    output logic                  load_err
);

    localparam logic [7:0]  CMD_I   = 8'h49;
    localparam logic [7:0]  CMD_D   = 8'h44;
    localparam logic [7:0]  CMD_G   = 8'h47;
    localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    take;
    logic                    tgt_d;
    logic [7:0]              cnt_lo;
    logic [15:0]             cnt_full;
    logic [15:0]             words_left;
    logic [1:0]              byte_cnt;
    logic [23:0]             acc;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [31:0]             word;

    assign take     = in_valid & in_ready;
    assign cnt_full = {in_data, cnt_lo};
    assign word     = {in_data, acc};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and byte acceptance.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (take) begin
                    if (in_data == CMD_I || in_data == CMD_D) state_nxt = S_CNT_LO;
                    else if (in_data == CMD_G)                state_nxt = S_DONE;
                    else                                      state_nxt = S_ERR;
                end
            end
            S_CNT_LO: begin
                in_ready = 1'b1;
                if (take) state_nxt = S_CNT_HI;
            end
            S_CNT_HI: begin
                in_ready = 1'b1;
                if (take) begin
                    if (cnt_full == 16'd0)      state_nxt = S_IDLE;
                    else if (cnt_full > MAX_CNT) state_nxt = S_ERR;
                    else                         state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (take && byte_cnt == 2'd3 && words_left == 16'd1) state_nxt = S_IDLE;
            end
            S_DONE:  state_nxt = S_DONE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_ERR;
        endcase
    end

    // Word assembly, BRAM write ports and sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_d      <= 1'b0;
            cnt_lo     <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            acc        <= '0;
            word_addr  <= '0;
            i_w_addr   <= '0;
            i_w_dat    <= '0;
            i_w_enb    <= 1'b0;
            d_w_addr   <= '0;
            d_w_dat    <= '0;
            d_w_enb    <= 1'b0;
            cpu_stall  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            i_w_enb   <= 1'b0;
            d_w_enb   <= 1'b0;
            cpu_stall <= (state_nxt != S_DONE);
            load_done <= (state_nxt == S_DONE);
            load_err  <= (state_nxt == S_ERR);
            if (take) begin
                case (state)
                    S_IDLE:   tgt_d  <= (in_data == CMD_D);
                    S_CNT_LO: cnt_lo <= in_data;
                    S_CNT_HI: begin
                        words_left <= cnt_full;
                        byte_cnt   <= 2'd0;
                        word_addr  <= '0;
                    end
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: acc[7:0]   <= in_data;
                            2'd1: acc[15:8]  <= in_data;
                            2'd2: acc[23:16] <= in_data;
                            default: begin
                                // Final byte of the word: write it out and step the segment.
                                if (tgt_d) begin
                                    d_w_addr <= word_addr;
                                    d_w_dat  <= DATA_WIDTH'(word);
                                    d_w_enb  <= 1'b1;
                                end else begin
                                    i_w_addr <= word_addr;
                                    i_w_dat  <= DATA_WIDTH'(word);
                                    i_w_enb  <= 1'b1;
                                end
                                word_addr  <= word_addr + ADDR_WIDTH'(4);
                                words_left <= words_left - 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table vectors, hand-written timing sequences and
// randomized frames scored against a frame-parsing reference model.
module tb_prog_loader;

    typedef logic [7:0] byte_q[$];
    typedef struct packed {
        logic        tgt;
        logic [9:0]  addr;
        logic [31:0] dat;
    } wr_t;
    typedef wr_t wr_q[$];

    typedef struct packed {
        logic [63:0] data;
        int          len;
        int          exp_acc;
        logic        exp_done;
        logic        exp_err;
        int          exp_nw;
        logic        exp_tgt;
        logic [31:0] exp_w0;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [9:0]  i_w_addr, d_w_addr;
    logic [31:0] i_w_dat, d_w_dat;
    logic        i_w_enb, d_w_enb;
    logic        cpu_stall, load_done, load_err;

    int checks = 0;
    int failures = 0;
    wr_q cap;

    prog_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WORDS(256)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
        .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
        .cpu_stall(cpu_stall), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Capture every write-enable cycle away from the active edge.
    always @(negedge clk) begin
        if (i_w_enb) cap.push_back({1'b0, i_w_addr, i_w_dat});
        if (d_w_enb) cap.push_back({1'b1, d_w_addr, d_w_dat});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: parse the frame stream directly, listing the writes and how
    // many bytes get consumed before the loader goes terminal or runs dry.
    function automatic void model(input byte_q bs, output wr_q ew, output int acc,
                                  output bit done, output bit err);
        int p = 0;
        int n = bs.size();
        ew = {};
        done = 0;
        err = 0;
        while (p < n) begin
            logic [7:0] cmd = bs[p];
            p++;
            if (cmd == 8'h47) begin
                done = 1;
                break;
            end else if (cmd == 8'h49 || cmd == 8'h44) begin
                int cnt;
                if (p + 2 > n) begin p = n; break; end
                cnt = int'(bs[p]) + 256 * int'(bs[p+1]);
                p += 2;
                if (cnt > 256) begin err = 1; break; end
                for (int k = 0; k < cnt; k++) begin
                    wr_t w;
                    if (p + 4 > n) begin p = n; break; end
                    w.tgt  = (cmd == 8'h44);
                    w.addr = 10'((k * 4) % 1024);
                    w.dat  = {bs[p+3], bs[p+2], bs[p+1], bs[p]};
                    ew.push_back(w);
                    p += 4;
                end
            end else begin
                err = 1;
                break;
            end
        end
        acc = p;
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
        int n = 0;
        if (gaps) begin
            int g = $urandom_range(0, 2);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat (g) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 0;
        while (!ok && n < 8) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1 ok = 1;
            end else begin
                n++;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_stream(input byte_q bs, input bit gaps, output int acc);
        bit ok;
        acc = 0;
        foreach (bs[i]) begin
            send_byte(bs[i], gaps, ok);
            if (!ok) break;
            acc++;
        end
    endtask

    task automatic run_stream(input string name, input byte_q bs, input bit gaps, input bit rst_first);
        wr_q ew;
        int  eacc, acc, nmin;
        bit  ed, ee;
        if (rst_first) do_reset();
        cap.delete();
        model(bs, ew, eacc, ed, ee);
        send_stream(bs, gaps, acc);
        repeat (3) @(posedge clk);
        #1;
        check({name, " accepted"}, 64'(acc), 64'(eacc));
        check({name, " nwrites"}, 64'(cap.size()), 64'(ew.size()));
        nmin = (cap.size() < ew.size()) ? cap.size() : ew.size();
        for (int i = 0; i < nmin; i++) check({name, " write"}, 64'(cap[i]), 64'(ew[i]));
        check({name, " done"}, 64'(load_done), 64'(ed));
        check({name, " err"}, 64'(load_err), 64'(ee));
        check({name, " stall"}, 64'(cpu_stall), 64'(!ed));
        check({name, " ready"}, 64'(in_ready), 64'(!(ed || ee)));
    endtask

    function automatic void push_word(inout byte_q bs, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bs.push_back(w[8*i +: 8]);
    endfunction

    vec_t vecs[7];

    initial begin
        byte_q bs;
        bit    ok;

        vecs[0] = '{64'h58,               1, 1, 1'b0, 1'b1, 0, 1'b0, 32'h0};
        vecs[1] = '{64'h47,               1, 1, 1'b1, 1'b0, 0, 1'b0, 32'h0};
        vecs[2] = '{64'h010149,           3, 3, 1'b0, 1'b1, 0, 1'b0, 32'h0};
        vecs[3] = '{64'h47000049,         4, 4, 1'b1, 1'b0, 0, 1'b0, 32'h0};
        vecs[4] = '{64'h4744332211000144, 8, 8, 1'b1, 1'b0, 1, 1'b1, 32'h44332211};
        vecs[5] = '{64'h41,               1, 1, 1'b0, 1'b1, 0, 1'b0, 32'h0};
        vecs[6] = '{64'h5847,             2, 1, 1'b1, 1'b0, 0, 1'b0, 32'h0};

        // Reset values.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst stall", 64'(cpu_stall), 64'd1);
        check("rst done", 64'(load_done), 64'd0);
        check("rst err", 64'(load_err), 64'd0);
        check("rst enb", 64'({i_w_enb, d_w_enb}), 64'd0);
        check("rst addr", 64'({i_w_addr, d_w_addr}), 64'd0);
        check("rst dat", {i_w_dat, d_w_dat}, 64'd0);
        rst = 1'b1;

        // Table vectors.
        for (int v = 0; v < 7; v++) begin
            int acc;
            do_reset();
            cap.delete();
            bs = {};
            for (int i = 0; i < vecs[v].len; i++) bs.push_back(vecs[v].data[8*i +: 8]);
            send_stream(bs, 1'b0, acc);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("vec%0d accepted", v), 64'(acc), 64'(vecs[v].exp_acc));
            check($sformatf("vec%0d done", v), 64'(load_done), 64'(vecs[v].exp_done));
            check($sformatf("vec%0d err", v), 64'(load_err), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d stall", v), 64'(cpu_stall), 64'(!vecs[v].exp_done));
            check($sformatf("vec%0d nwrites", v), 64'(cap.size()), 64'(vecs[v].exp_nw));
            if (vecs[v].exp_nw > 0 && cap.size() > 0)
                check($sformatf("vec%0d w0", v), 64'({cap[0].tgt, cap[0].addr, cap[0].dat}),
                      64'({vecs[v].exp_tgt, 10'h000, vecs[v].exp_w0}));
        end

        // Write latency, cmd accepted in the pulse cycle, go timing.
        do_reset();
        cap.delete();
        bs = '{8'h49, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34};
        foreach (bs[i]) send_byte(bs[i], 1'b0, ok);
        send_byte(8'h12, 1'b0, ok);
        check("lat accepted", 64'(ok), 64'd1);
        check("lat i_w_enb", 64'(i_w_enb), 64'd1);
        check("lat d_w_enb", 64'(d_w_enb), 64'd0);
        check("lat addr", 64'(i_w_addr), 64'h0);
        check("lat dat", 64'(i_w_dat), 64'h12345678);
        check("lat ready", 64'(in_ready), 64'd1);
        send_byte(8'h47, 1'b0, ok);
        check("go accepted", 64'(ok), 64'd1);
        check("go i_w_enb", 64'(i_w_enb), 64'd0);
        check("go stall", 64'(cpu_stall), 64'd0);
        check("go done", 64'(load_done), 64'd1);
        check("go ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 check("go nwrites", 64'(cap.size()), 64'd1);

        // Error timing.
        do_reset();
        send_byte(8'h58, 1'b0, ok);
        check("err flag", 64'(load_err), 64'd1);
        check("err ready", 64'(in_ready), 64'd0);
        check("err stall", 64'(cpu_stall), 64'd1);

        // Instruction segment then data segment then go; idle port holds.
        bs = '{8'h49, 8'h03, 8'h00};
        push_word(bs, 32'h00452503);
        push_word(bs, 32'h00452503);
        push_word(bs, 32'h00000013);
        run_stream("iseg", bs, 1'b0, 1'b1);
        run_stream("iseg_gaps", bs, 1'b1, 1'b1);
        bs = '{8'h44, 8'h02, 8'h00};
        push_word(bs, 32'h0000000A);
        push_word(bs, 32'h00000014);
        bs.push_back(8'h47);
        run_stream("dseg", bs, 1'b0, 1'b0);
        check("hold i_w_addr", 64'(i_w_addr), 64'h008);
        check("hold i_w_dat", 64'(i_w_dat), 64'h00000013);
        check("d_w_addr last", 64'(d_w_addr), 64'h004);
        check("d_w_dat last", 64'(d_w_dat), 64'h00000014);

        // Maximum-size segment.
        bs = '{8'h49, 8'h00, 8'h01};
        for (int i = 0; i < 1024; i++) bs.push_back(8'($urandom));
        run_stream("max256", bs, 1'b0, 1'b1);
        if (cap.size() > 0) check("max256 last addr", 64'(cap[cap.size()-1].addr), 64'h3FC);
        else check("max256 last addr", 64'hFFFF, 64'h3FC);

        // Reset in the middle of a word.
        do_reset();
        cap.delete();
        bs = '{8'h44, 8'h01, 8'h00, 8'hAA, 8'hBB};
        foreach (bs[i]) send_byte(bs[i], 1'b0, ok);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst enb", 64'({i_w_enb, d_w_enb}), 64'd0);
        check("midrst addr", 64'({i_w_addr, d_w_addr}), 64'd0);
        check("midrst dat", {i_w_dat, d_w_dat}, 64'd0);
        check("midrst flags", 64'({in_ready, cpu_stall, load_done, load_err}), 64'b1100);
        rst = 1'b1;
        @(posedge clk);
        #1 check("midrst nwrites", 64'(cap.size()), 64'd0);
        bs = '{8'h44, 8'h01, 8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        run_stream("after_rst", bs, 1'b0, 1'b0);

        // Randomized frames with random gaps.
        for (int it = 0; it < 6; it++) begin
            int nseg = $urandom_range(1, 3);
            bs = {};
            for (int s = 0; s < nseg; s++) begin
                int cnt = $urandom_range(1, 5);
                bs.push_back(($urandom_range(0, 1) == 0) ? 8'h49 : 8'h44);
                bs.push_back(8'(cnt));
                bs.push_back(8'h00);
                for (int k = 0; k < cnt; k++) push_word(bs, $urandom);
            end
            if ($urandom_range(0, 3) == 0) bs.push_back(8'h5A);
            else bs.push_back(8'h47);
            bs.push_back(8'h49);
            run_stream($sformatf("rand%0d", it), bs, 1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
